// File: rtl/wave_step_pipe_pkg.sv
// Shared types and fixed-point helpers for the wave step pipeline.
// Helpers work on 64-bit signed values so any stage width up to 64 can use them.
package wave_step_pipe_pkg;

   typedef enum logic [1:0] {
      MODE_EULER    = 2'd0,
      MODE_DAMP     = 2'd1,
      MODE_PASS     = 2'd2,
      MODE_PASS_ALT = 2'd3
   } mode_e;

   localparam int CPLX_W = 16;

   typedef struct packed {
      logic signed [CPLX_W-1:0] re;
      logic signed [CPLX_W-1:0] im;
   } cplx_t;

   function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic logic clips(input logic signed [63:0] x, input int w);
      return sat_s(x, w) != x;
   endfunction

   // Arithmetic right shift, i.e. division by 2^sh rounded toward -inf.
   function automatic logic signed [63:0] asr_floor(input logic signed [63:0] x, input int sh);
      return x >>> sh;
   endfunction

   function automatic logic is_pass(input mode_e m);
      return (m == MODE_PASS) || (m == MODE_PASS_ALT);
   endfunction

endpackage

// File: rtl/wave_step_pipe_cplx_sat.sv
// Saturates a wide complex value to OUT_W bits per component and flags clipping.
module wave_cplx_sat
   import wave_step_pipe_pkg::*;
#(
   parameter int IN_W  = 39,
   parameter int OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  re_in,
   input  logic signed [IN_W-1:0]  im_in,
   output logic signed [OUT_W-1:0] re_out,
   output logic signed [OUT_W-1:0] im_out,
   output logic                    sat
);

   logic signed [63:0] re_x;
   logic signed [63:0] im_x;

   assign re_x   = 64'(re_in);
   assign im_x   = 64'(im_in);
   assign re_out = OUT_W'(sat_s(re_x, OUT_W));
   assign im_out = OUT_W'(sat_s(im_x, OUT_W));
   assign sat    = clips(re_x, OUT_W) | clips(im_x, OUT_W);

endmodule

// File: rtl/wave_step_pipe.sv
// Three-stage Schroedinger-style Euler step on a stream of lattice sites,
// with a global-stall pipeline and a per-frame |psi|^2 accumulator.
module wave_step_pipe
   import wave_step_pipe_pkg::*;
#(
   parameter int PSI_W    = 16,
   parameter int PSI_FRAC = 8,
   parameter int V_W      = 16,
   parameter int V_FRAC   = 12,
   parameter int DT_W     = 16,
   parameter int ACC_W    = 40
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*PSI_W-1:0]   in_c,
   input  logic [2*PSI_W-1:0]   in_n,
   input  logic [2*PSI_W-1:0]   in_s,
   input  logic [2*PSI_W-1:0]   in_e,
   input  logic [2*PSI_W-1:0]   in_w,
   input  logic [V_W-1:0]       in_v,
   input  logic                 in_last,
   input  logic [DT_W-1:0]      dt,
   input  logic [DT_W-1:0]      damp,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*PSI_W-1:0]   out_psi,
   output logic                 out_sat,
   output logic                 out_last,
   output logic                 norm_valid,
   output logic [ACC_W-1:0]     norm_sum
);

   localparam int LW  = PSI_W + 3;
   localparam int DW  = PSI_W + 4;
   localparam int VPW = V_W + PSI_W;
   localparam int PW  = DT_W + 1 + DW;
   localparam int QW  = DT_W + 1 + PSI_W;
   localparam int SW  = PW + 2;
   localparam int SQW = 2 * PSI_W;
   localparam int AW1 = ACC_W + 1;

   typedef struct packed {
      logic signed [PSI_W-1:0] re;
      logic signed [PSI_W-1:0] im;
   } psi_c_t;

   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Stage 1: discrete Laplacian, exact at PSI_W+3 bits
   psi_c_t c0, n0, s0, e0, w0;
   assign c0 = in_c;
   assign n0 = in_n;
   assign s0 = in_s;
   assign e0 = in_e;
   assign w0 = in_w;

   logic signed [LW-1:0] lap_re, lap_im;
   assign lap_re = LW'(n0.re) + LW'(s0.re) + LW'(e0.re) + LW'(w0.re) - (LW'(c0.re) <<< 2);
   assign lap_im = LW'(n0.im) + LW'(s0.im) + LW'(e0.im) + LW'(w0.im) - (LW'(c0.im) <<< 2);

   logic                  s1_valid, s1_last;
   psi_c_t                s1_c;
   logic signed [LW-1:0]  s1_lap_re, s1_lap_im;
   logic signed [V_W-1:0] s1_v;
   logic [DT_W-1:0]       s1_dt, s1_damp;
   mode_e                 s1_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_c      <= '0;
         s1_lap_re <= '0;
         s1_lap_im <= '0;
         s1_v      <= '0;
         s1_dt     <= '0;
         s1_damp   <= '0;
         s1_mode   <= MODE_EULER;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s1_last   <= in_last;
         s1_c      <= c0;
         s1_lap_re <= lap_re;
         s1_lap_im <= lap_im;
         s1_v      <= $signed(in_v);
         s1_dt     <= dt;
         s1_damp   <= damp;
         s1_mode   <= mode_e'(mode);
      end
   end

   // Stage 2: d = lap - (V*psi) >>> V_FRAC
   logic signed [VPW-1:0] vp_re, vp_im;
   logic signed [DW-1:0]  d_re, d_im;
   assign vp_re = VPW'(s1_v) * VPW'(s1_c.re);
   assign vp_im = VPW'(s1_v) * VPW'(s1_c.im);
   assign d_re  = DW'(s1_lap_re) - DW'(asr_floor(64'(vp_re), V_FRAC));
   assign d_im  = DW'(s1_lap_im) - DW'(asr_floor(64'(vp_im), V_FRAC));

   logic                 s2_valid, s2_last;
   psi_c_t               s2_c;
   logic signed [DW-1:0] s2_d_re, s2_d_im;
   logic [DT_W-1:0]      s2_dt, s2_damp;
   mode_e                s2_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_c     <= '0;
         s2_d_re  <= '0;
         s2_d_im  <= '0;
         s2_dt    <= '0;
         s2_damp  <= '0;
         s2_mode  <= MODE_EULER;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_last  <= s1_last;
         s2_c     <= s1_c;
         s2_d_re  <= d_re;
         s2_d_im  <= d_im;
         s2_dt    <= s1_dt;
         s2_damp  <= s1_damp;
         s2_mode  <= s1_mode;
      end
   end

   // Stage 3: rotate by dt*d, optional damping, then saturate
   logic signed [PW-1:0] dt_s, p_re, p_im;
   logic signed [QW-1:0] dmp_s, q_re, q_im;
   logic signed [SW-1:0] nxt_re, nxt_im;

   assign dt_s  = PW'($signed({1'b0, s2_dt}));
   assign p_re  = dt_s * PW'(s2_d_re);
   assign p_im  = dt_s * PW'(s2_d_im);
   assign dmp_s = QW'($signed({1'b0, s2_damp}));
   assign q_re  = dmp_s * QW'(s2_c.re);
   assign q_im  = dmp_s * QW'(s2_c.im);

   always_comb begin
      nxt_re = SW'(s2_c.re);
      nxt_im = SW'(s2_c.im);
      if (!is_pass(s2_mode)) begin
         nxt_re = nxt_re - SW'(asr_floor(64'(p_im), DT_W));
         nxt_im = nxt_im + SW'(asr_floor(64'(p_re), DT_W));
         if (s2_mode == MODE_DAMP) begin
            nxt_re = nxt_re - SW'(asr_floor(64'(q_re), DT_W));
            nxt_im = nxt_im - SW'(asr_floor(64'(q_im), DT_W));
         end
      end
   end

   logic signed [PSI_W-1:0] res_re, res_im;
   logic                    res_sat;

   wave_cplx_sat #(
      .IN_W  (SW),
      .OUT_W (PSI_W)
   ) u_sat (
      .re_in  (nxt_re),
      .im_in  (nxt_im),
      .re_out (res_re),
      .im_out (res_im),
      .sat    (res_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_psi   <= '0;
         out_sat   <= 1'b0;
         out_last  <= 1'b0;
      end else if (advance) begin
         out_valid <= s2_valid;
         out_psi   <= {res_re, res_im};
         out_sat   <= res_sat;
         out_last  <= s2_last;
      end
   end

   // Frame norm: accumulate on each output handshake, publish and clear on last
   logic signed [PSI_W-1:0] o_re, o_im;
   logic signed [SQW-1:0]   sq_re, sq_im;
   logic [SQW:0]            sq_sum, sq_shift;
   logic [ACC_W-1:0]        acc, acc_sat;
   logic [AW1-1:0]          acc_sum;
   logic                    out_fire;

   assign o_re     = $signed(out_psi[2*PSI_W-1 -: PSI_W]);
   assign o_im     = $signed(out_psi[PSI_W-1:0]);
   assign sq_re    = SQW'(o_re) * SQW'(o_re);
   assign sq_im    = SQW'(o_im) * SQW'(o_im);
   assign sq_sum   = {1'b0, sq_re} + {1'b0, sq_im};
   assign sq_shift = sq_sum >> PSI_FRAC;
   assign acc_sum  = {1'b0, acc} + AW1'(sq_shift);
   assign acc_sat  = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         norm_valid <= 1'b0;
         norm_sum   <= '0;
      end else begin
         norm_valid <= 1'b0;
         if (out_fire) begin
            if (out_last) begin
               acc        <= '0;
               norm_valid <= 1'b1;
               norm_sum   <= acc_sat;
            end else begin
               acc <= acc_sat;
            end
         end
      end
   end

endmodule

// File: tb/tb_wave_step_pipe.sv
// Randomized and directed bench for wave_step_pipe with a behavioural model
// built from integer arithmetic and a queue of expected beats.
module tb_wave_step_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_last;
   logic [31:0] in_c, in_n, in_s, in_e, in_w;
   logic [15:0] in_v, dt, damp;
   logic [1:0]  mode;
   logic        out_valid, out_ready, out_sat, out_last, norm_valid;
   logic [31:0] out_psi;
   logic [39:0] norm_sum;

   always #5 clk = ~clk;

   wave_step_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_c(in_c), .in_n(in_n), .in_s(in_s), .in_e(in_e), .in_w(in_w),
      .in_v(in_v), .in_last(in_last), .dt(dt), .damp(damp), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_psi(out_psi),
      .out_sat(out_sat), .out_last(out_last), .norm_valid(norm_valid),
      .norm_sum(norm_sum)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam longint ACC_MAX = (longint'(1) << 40) - 1;

   function automatic longint fl(input longint a, input int k);
      longint p, q;
      p = longint'(1) << k;
      q = a / p;
      if ((a % p) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   function automatic longint hre(input logic [31:0] x);
      return longint'($signed(x[31:16]));
   endfunction

   function automatic longint him(input logic [31:0] x);
      return longint'($signed(x[15:0]));
   endfunction

   function automatic logic [31:0] pk(input int re, input int im);
      logic [31:0] r;
      r = {re[15:0], im[15:0]};
      return r;
   endfunction

   function automatic void model(input logic [31:0] c, n, s, e, w,
                                 input logic [15:0] v, dtv, dmp, input logic [1:0] md,
                                 output longint ore, output longint oim, output bit osat);
      longint lr, li, dr, di, r, i, vv, t, dd;
      vv = longint'($signed(v));
      t  = longint'(dtv);
      dd = longint'(dmp);
      osat = 1'b0;
      if (md >= 2) begin
         ore = hre(c);
         oim = him(c);
         return;
      end
      lr = hre(n) + hre(s) + hre(e) + hre(w) - 4 * hre(c);
      li = him(n) + him(s) + him(e) + him(w) - 4 * him(c);
      dr = lr - fl(vv * hre(c), 12);
      di = li - fl(vv * him(c), 12);
      r  = hre(c) - fl(t * di, 16);
      i  = him(c) + fl(t * dr, 16);
      if (md == 1) begin
         r = r - fl(dd * hre(c), 16);
         i = i - fl(dd * him(c), 16);
      end
      if (r > 32767)  begin r = 32767;  osat = 1'b1; end
      if (r < -32768) begin r = -32768; osat = 1'b1; end
      if (i > 32767)  begin i = 32767;  osat = 1'b1; end
      if (i < -32768) begin i = -32768; osat = 1'b1; end
      ore = r;
      oim = i;
   endfunction

   function automatic longint sqnorm(input longint re, input longint im);
      return (re * re + im * im) / 256;
   endfunction

   typedef struct {
      longint re;
      longint im;
      bit     sat;
      bit     last;
      int     acc_cyc;
      int     stall_at;
   } exp_t;

   exp_t        q[$];
   bit          head_seen, prev_stall, pend;
   logic [31:0] prev_psi;
   logic        prev_sat, prev_last;
   longint      acc_m, pend_val, norm_m, last_norm_dut;
   longint      last_re, last_im, last_sat;
   int          cyc, stall_cnt, n_out, n_pulses;

   initial begin
      head_seen = 0; prev_stall = 0; pend = 0; acc_m = 0; pend_val = 0; norm_m = 0;
      last_norm_dut = 0; last_re = 0; last_im = 0; last_sat = 0;
      cyc = 0; stall_cnt = 0; n_out = 0; n_pulses = 0;
      prev_psi = '0; prev_sat = 1'b0; prev_last = 1'b0;
   end

   // compare process: all sampling on the falling edge
   always @(negedge clk) begin
      exp_t   ex, h;
      longint r, i;
      bit     s;
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_norm_sum", norm_sum, 0);
         chk("rst_norm_valid", norm_valid, 0);
         chk("rst_out_psi", out_psi, 0);
         q.delete();
         acc_m = 0; pend = 0; norm_m = 0; head_seen = 0; prev_stall = 0;
      end else begin
         if (pend) begin
            chk("norm_valid", norm_valid, 1);
            chk("norm_sum", norm_sum, pend_val);
            norm_m = pend_val;
            last_norm_dut = longint'(norm_sum);
            n_pulses++;
         end else begin
            chk("norm_idle", norm_valid, 0);
            chk("norm_hold", norm_sum, norm_m);
         end
         pend = 0;
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_psi", out_psi, prev_psi);
            chk("stall_sat", out_sat, prev_sat);
            chk("stall_last", out_last, prev_last);
         end
         chk("in_ready", in_ready, !(out_valid && !out_ready));
         if (out_valid) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got out_valid=1 expected no beat in flight");
            end else begin
               h = q[0];
               if (!head_seen) begin
                  head_seen = 1;
                  chk("latency", cyc - h.acc_cyc, 3 + stall_cnt - h.stall_at);
               end
               if (out_ready) begin
                  ex = q.pop_front();
                  head_seen = 0;
                  chk("out_re", longint'($signed(out_psi[31:16])), ex.re);
                  chk("out_im", longint'($signed(out_psi[15:0])), ex.im);
                  chk("out_sat", out_sat, ex.sat);
                  chk("out_last", out_last, ex.last);
                  last_re = longint'($signed(out_psi[31:16]));
                  last_im = longint'($signed(out_psi[15:0]));
                  last_sat = longint'(out_sat);
                  n_out++;
                  acc_m = acc_m + sqnorm(ex.re, ex.im);
                  if (acc_m > ACC_MAX) acc_m = ACC_MAX;
                  if (ex.last) begin
                     pend = 1;
                     pend_val = acc_m;
                     acc_m = 0;
                  end
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_psi = out_psi;
         prev_sat = out_sat;
         prev_last = out_last;
         if (in_valid && in_ready) begin
            model(in_c, in_n, in_s, in_e, in_w, in_v, dt, damp, mode, r, i, s);
            ex.re = r; ex.im = i; ex.sat = s; ex.last = in_last;
            ex.acc_cyc = cyc; ex.stall_at = stall_cnt;
            q.push_back(ex);
         end
         if (out_valid && !out_ready) stall_cnt++;
      end
      cyc++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_all(input logic [31:0] x);
      in_c = x; in_n = x; in_s = x; in_e = x; in_w = x;
   endtask

   task automatic push_beat();
      bit ok;
      ok = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got in_ready=0 for 1000 cycles expected 1");
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
      chk("drain", q.size(), 0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   function automatic int rv();
      if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 1200)) - 600;
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic rand_beat();
      in_c = pk(rv(), rv()); in_n = pk(rv(), rv()); in_s = pk(rv(), rv());
      in_e = pk(rv(), rv()); in_w = pk(rv(), rv());
      in_v = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 8191));
      dt = 16'($urandom_range(0, 65535));
      damp = 16'($urandom_range(0, 65535));
      mode = 2'($urandom_range(0, 3));
      in_last = ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      longint r, i;
      bit     s;
      int     n0, p0;
      bit     done_flag;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      set_all('0); in_v = '0; dt = '0; damp = '0; mode = '0; in_last = 1'b0;

      // hand-computed anchors for the model itself
      model(pk(256, 0), pk(256, 0), pk(256, 0), pk(256, 0), pk(256, 0), 0, 655, 0, 0, r, i, s);
      chk("pin_uniform_re", r, 256); chk("pin_uniform_im", i, 0); chk("pin_uniform_sat", s, 0);
      model(pk(0, 256), 0, 0, 0, 0, 0, 655, 0, 0, r, i, s);
      chk("pin_excite_re", r, 11); chk("pin_excite_im", i, 256);
      model(pk(32767, 0), 0, 0, 0, 0, 0, 65535, 0, 0, r, i, s);
      chk("pin_sat_re", r, 32767); chk("pin_sat_im", i, -32768); chk("pin_sat_flag", s, 1);
      model(pk(100, -50), pk(7, 7), pk(9, 1), pk(-3, 2), pk(5, 5), 16'h1234, 655, 0, 2, r, i, s);
      chk("pin_pass_re", r, 100); chk("pin_pass_im", i, -50);
      model(pk(256, 0), pk(256, 0), pk(256, 0), pk(256, 0), pk(256, 0), 0, 655, 32768, 1, r, i, s);
      chk("pin_damp_re", r, 128);
      chk("pin_norm", sqnorm(256, 0), 256);

      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // uniform field
      set_all(pk(256, 0)); in_v = 0; dt = 655; damp = 0; mode = 0; in_last = 1;
      push_beat();
      drain();
      chk("uniform_re", last_re, 256);

      // single excitation
      set_all('0); in_c = pk(0, 256);
      push_beat();
      drain();
      chk("excite_re", last_re, 11);
      chk("excite_im", last_im, 256);

      // saturation
      set_all('0); in_c = pk(32767, 0); dt = 65535;
      push_beat();
      drain();
      chk("sat_im", last_im, -32768);
      chk("sat_flag", last_sat, 1);

      // frame norm, then restart and back-to-back last beats
      set_all(pk(256, 0)); dt = 655;
      p0 = n_pulses;
      for (int k = 0; k < 4; k++) begin
         in_last = (k == 3);
         push_beat();
      end
      drain();
      chk("frame_pulses", n_pulses - p0, 1);
      chk("frame_norm", last_norm_dut, 1024);
      p0 = n_pulses;
      in_last = 1;
      push_beat();
      push_beat();
      drain();
      chk("restart_pulses", n_pulses - p0, 2);
      chk("restart_norm", last_norm_dut, 256);

      // backpressure mid-stream
      n0 = n_out;
      fork
         begin
            for (int k = 0; k < 10; k++) begin
               set_all(pk(20 * k + 1, -3 * k - 2));
               in_c = pk(40 * k + 5, 7 * k);
               in_v = 16'(k * 300);
               in_last = (k == 9);
               push_beat();
            end
         end
         begin
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            repeat (2) @(negedge clk);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_count", n_out - n0, 10);

      // reset with beats in flight, then pass-through
      set_all(pk(300, 300)); in_v = 0; mode = 0; in_last = 0;
      push_beat();
      push_beat();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst_quiet", out_valid, 0);
      end
      @(posedge clk);
      #1;
      in_c = pk(100, -50); in_n = pk(7, 7); in_s = pk(9, 1); in_e = pk(-3, 2); in_w = pk(5, 5);
      in_v = 16'h1234; mode = 2; in_last = 1;
      push_beat();
      drain();
      chk("pass_re", last_re, 100);
      chk("pass_im", last_im, -50);
      chk("pass_sat", last_sat, 0);

      // randomized traffic with random backpressure
      done_flag = 0;
      fork
         begin
            for (int k = 0; k < 400; k++) begin
               rand_beat();
               if ($urandom_range(0, 3) == 0) begin
                  repeat ($urandom_range(1, 3)) @(posedge clk);
                  #1;
               end
               push_beat();
            end
            done_flag = 1;
         end
         begin
            while (!done_flag) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 9) < 7);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wave_step_pipe.md
WAVE_STEP_PIPE -- requirements
Module: wave_step_pipe

Interface
REQ-001 SHALL have parameter PSI_W, default 16, meaning Ψ component width (signed).
REQ-002 SHALL have parameter PSI_FRAC, default 8, meaning Ψ fractional bits.
REQ-003 SHALL have parameter V_W, default 16, meaning potential width (signed).
REQ-004 SHALL have parameter V_FRAC, default 12, meaning potential fractional bits.
REQ-005 SHALL have parameter DT_W, default 16, meaning unsigned dt/damp width, all fractional bits.
REQ-006 SHALL have parameter ACC_W, default 40, meaning norm accumulator width.
REQ-007 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_c, in_n, in_s, in_e, in_w  in  2*PSI_W each  complex {re,im}: centre site and its four neighbours.
- in_v  in  V_W  local potential.
- in_last  in  1  last site of frame.
- dt  in  DT_W  time step.
- damp  in  DT_W  damping coefficient.
- mode  in  2  0=Euler, 1=Euler+damping, 2/3=pass-through.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_psi  out  2*PSI_W  updated Ψ.
- out_sat  out  1  a component of out_psi saturated.
- out_last  out  1  in_last delayed with its beat.
- norm_valid  out  1  one-cycle frame-norm strobe.
- norm_sum  out  ACC_W  Σ|Ψ|² over the frame.

Function
REQ-008 dt, damp and mode SHALL be captured with each accepted beat and travel with it through the pipe.
REQ-009 Stage 1 SHALL compute lap = N+S+E+W−4C per component at PSI_W+3 bits with no loss.
REQ-010 Stage 2 SHALL compute Vψ = (V·ψ)>>>V_FRAC per component and d = lap − Vψ at PSI_W+4 bits.
REQ-011 Stage 3 SHALL compute:
- re' = re − (dt·d_im)>>>DT_W
- im' = im + (dt·d_re)>>>DT_W
REQ-012 All shifts SHALL be arithmetic, i.e. floor rounding.
REQ-013 In mode 1, Stage 3 SHALL additionally subtract (damp·re)>>>DT_W from re' and (damp·im)>>>DT_W from im'.
REQ-014 In modes 2 and 3, out_psi SHALL equal in_c unchanged, with out_sat=0.
REQ-015 Each result component SHALL saturate to [−2^(PSI_W−1), 2^(PSI_W−1)−1].
REQ-016 out_sat SHALL be 1 if either component clipped.
REQ-017 Latency SHALL be exactly 3 cycles from input acceptance to out_valid when out_ready is held high.
REQ-018 Throughput SHALL be 1 beat/cycle when out_ready is held high.
REQ-019 Flow control SHALL use a global stall:
- advance = !out_valid || out_ready
- in_ready = advance
- every stage register holds while advance=0
- no beat is lost or duplicated
REQ-020 out_psi, out_sat and out_last SHALL stay stable while out_valid && !out_ready.
REQ-021 On each output handshake, the accumulator SHALL add (re'²+im'²)>>>PSI_FRAC, saturating at 2^ACC_W−1.
REQ-022 On an output handshake with out_last=1, the next cycle SHALL assert norm_valid=1 for one cycle with norm_sum including that beat, and clear the accumulator.
REQ-023 A beat with out_last=1 arriving in the same cycle norm_valid asserts SHALL start the new frame's sum, not the old one.
REQ-024 norm_sum SHALL hold its value until the next strobe.

Reset
REQ-025 When rst_n=0, all stage valids, out_valid, out_sat, out_last, norm_valid, out_psi, norm_sum and the accumulator SHALL clear to 0 asynchronously.
REQ-026 When rst_n=0, in_ready SHALL read 1.
REQ-027 Reset mid-frame SHALL discard in-flight beats and the partial norm.
REQ-028 The first beat after reset release SHALL appear 3 cycles after acceptance.

Structure
REQ-029 The complex type with parameterised width, the mode enum, and sat/floor-shift helper functions SHALL live in the shared wave package.
REQ-030 A sub-module wave_cplx_sat (one complex saturate plus flag) SHALL be instantiated in Stage 3.
REQ-031 The norm accumulator SHALL be inline.

Verification
REQ-032 The bench SHALL cover these directed scenarios at default parameters:
- Uniform field: all sites (256,0), V=0, dt=655, mode 0 -> out_psi=(256,0), out_sat=0, 3-cycle latency.
- Single excitation: C=(0,256), neighbours 0, V=0, dt=655, mode 0 -> out_psi=(11,256).
- Saturation: C=(32767,0), neighbours 0, V=0, dt=65535 -> out_psi=(32767,−32768), out_sat=1.
- Frame norm: 4 beats of (256,0) uniform, last on 4th -> single norm_valid pulse with norm_sum=1024, then accumulator restarts at 0.
- Backpressure: stream 10 beats with out_ready low for 5 cycles mid-stream -> in_ready drops once 3 beats are in flight, all 10 outputs in order, stable while stalled.
- Reset and mode 2: rst_n low with 2 beats in flight -> no out_valid after release; mode 2 with C=(100,−50) -> out_psi=(100,−50).
